mem_io_unit: RTL and testbench
==============================

Name: mem_io_unit

Overview:
- Memory/IO access stage that drives the `read_data` writeback input of the decode/register-file stage.
- Takes the effective address (`ALU_result`) and store data (`read_data_2`) from decode/execute.
- Sequences data-RAM and memory-mapped IO transactions, and stalls the single-cycle core while an access is outstanding.
- Data RAM is synchronous with 1-cycle read latency; IO devices use a req/ack handshake.

Parameters:
- MEM_ADDR_W, 14, word-address width of data RAM (64 KB).
- IO_BASE_HI, 22'h3FFFFF, `addr[31:10]` value selecting IO space (0xFFFFFC00–0xFFFFFFFF).
- IO_TIMEOUT, 255, cycles to wait for `io_ack` before aborting.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-low (0 = reset, sampled on posedge clock).
- MemRead  in  1  from control: current instruction is a load.
- MemWrite  in  1  from control: current instruction is a store.
- addr  in  32  effective address (`ALU_result`).
- wdata  in  32  store data (`read_data_2`).
- read_data  out  32  load result to decode writeback; registered.
- stall  out  1  freeze PC/RegWrite while 1.
- misalign  out  1  one-cycle pulse: access with `addr[1:0]!=0` was dropped.
- io_err  out  1  sticky IO timeout flag.
- mem_addr  out  MEM_ADDR_W  RAM word address = `addr[MEM_ADDR_W+1:2]`.
- mem_wdata  out  32  RAM write data.
- mem_we  out  1  RAM write enable.
- mem_rdata  in  32  RAM read data, valid the cycle after the address.
- io_addr  out  10  `addr[9:0]`, registered at request.
- io_wdata  out  32  registered store data.
- io_we  out  1  1 = IO write, held with `io_req`.
- io_req  out  1  IO request; held until ack or timeout.
- io_ack  in  1  device accepts/returns data this cycle.
- io_rdata  in  32  valid when `io_ack`=1.

Behaviour:
- **Reset** (reset==0 at posedge):
  - state=IDLE.
  - read_data=0, io_req=0, io_we=0, io_addr=0, io_wdata=0, io_err=0, misalign=0, timeout counter=0.
  - Applies mid-transaction too: `io_req` drops at that edge and the access is abandoned.
- **Decode:**
  - isio = `addr[31:10]==IO_BASE_HI`.
  - An access happens when MemRead|MemWrite. If both are set, treat it as a write.
- **States:** IDLE, MEM_RD, IO_WAIT, DONE. `stall` is combinational, defined per state below.
- **IDLE, no access:** stall=0, mem_we=0.
- **IDLE, misaligned access:**
  - No RAM/IO activity, stall=0.
  - misalign=1 next cycle for exactly one cycle; read_data unchanged.
- **IDLE, RAM write:**
  - mem_we=1 combinationally this cycle; mem_addr/mem_wdata driven from inputs.
  - stall=0; remain IDLE (0 extra cycles).
- **IDLE, RAM read:** stall=1; mem_addr driven; next state MEM_RD.
- **MEM_RD:** stall=1; read_data <= mem_rdata; next state DONE.
- **IDLE, IO access:**
  - stall=1.
  - Register io_addr, io_wdata, io_we; io_req <= 1; counter <= 0.
  - Next state IO_WAIT.
- **IO_WAIT:**
  - stall=1; io_req held at 1 with stable addr/data/we.
  - On io_ack: io_req <= 0; read_data <= io_rdata if read (unchanged if write); next state DONE.
  - Otherwise counter increments. When the counter reaches IO_TIMEOUT-1 without ack:
    - io_req <= 0; io_err <= 1 (sticky until reset).
    - read_data <= 32'h0 if read.
    - Next state DONE.
  - An io_ack in the same cycle as timeout wins; no error.
- **DONE:**
  - stall=0; the core commits writeback using read_data.
  - No new access is evaluated; next state IDLE. The next instruction is seen in IDLE.
- **Latencies (total cycles an instruction occupies):**
  - RAM store: 1.
  - RAM load: 3 (IDLE, MEM_RD, DONE).
  - IO: 3 + ack wait.
- `io_ack` outside IO_WAIT is ignored.
- `mem_we` is never 1 outside IDLE.

Decomposition:
- Shared package (`mem_io_pkg`): state encoding constants, IO_BASE_HI, IO_TIMEOUT default, and the decoded access-type constants NONE/MEM_RD/MEM_WR/IO_RD/IO_WR.
- One natural sub-module: `io_timeout_counter`, a loadable up-counter with a terminal-count output.
- Everything else stays in a single FSM module.

Test Plan:
- Store addr=0x00000010, wdata=0xCAFEF00D → mem_we=1 same cycle, mem_addr=4, stall=0; subsequent load of 0x10 → stall high 2 cycles, read_data=0xCAFEF00D in DONE.
- IO read addr=0xFFFFFC70, device acks after 5 cycles with 0x0000ABCD → io_addr=0x070, io_req high 5 cycles, read_data=0x0000ABCD, io_err=0.
- IO write with ack never asserted, IO_TIMEOUT=8 → io_req drops after 8 cycles, io_err=1 and stays 1 through later successful accesses until reset=0.
- Load addr=0x00000006 → misalign pulse 1 cycle, stall=0, mem_we=0, io_req=0, read_data unchanged.
- reset=0 asserted during IO_WAIT → next edge io_req=0, stall=0, state IDLE, read_data=0; a late io_ack is ignored.
- MemRead=MemWrite=1 at RAM address 0x20 → performed as a write (mem_we=1, no stall).

Source files
------------

// File: rtl/mem_io_unit_pkg.sv
// Shared types and defaults for the memory/IO access stage.
// Holds FSM states, decoded access kinds and the access decoder.
package mem_io_pkg;

  localparam int          MEM_ADDR_W_DEF = 14;
  localparam logic [21:0] IO_BASE_HI_DEF = 22'h3FFFFF;
  localparam int          IO_TIMEOUT_DEF = 255;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MEM_RD,
    ST_IO_WAIT,
    ST_DONE
  } state_t;

  typedef enum logic [2:0] {
    ACC_NONE,
    ACC_MEM_RD,
    ACC_MEM_WR,
    ACC_IO_RD,
    ACC_IO_WR
  } acc_t;

  // Load+store together is a store.
  function automatic acc_t decode_acc(
    input logic        rd,
    input logic        wr,
    input logic [31:0] a,
    input logic [21:0] base
  );
    logic isio;
    acc_t acc;
    isio = (a[31:10] == base);
    acc  = ACC_NONE;
    unique case (1'b1)
      wr:        acc = isio ? ACC_IO_WR : ACC_MEM_WR;
      rd && !wr: acc = isio ? ACC_IO_RD : ACC_MEM_RD;
      default:   acc = ACC_NONE;
    endcase
    return acc;
  endfunction

endpackage

// File: rtl/mem_io_unit_if.sv
// RAM and IO device bus of the memory/IO stage.
// master: the access unit; slave: data RAM plus IO devices.
interface mem_io_unit_if #(
  parameter int MEM_ADDR_W = 14
);

  logic [MEM_ADDR_W-1:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic                  mem_we;
  logic [31:0]           mem_rdata;
  logic [9:0]            io_addr;
  logic [31:0]           io_wdata;
  logic                  io_we;
  logic                  io_req;
  logic                  io_ack;
  logic [31:0]           io_rdata;

  modport master (
    output mem_addr, mem_wdata, mem_we,
    output io_addr, io_wdata, io_we, io_req,
    input  mem_rdata, io_ack, io_rdata
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_we,
    input  io_addr, io_wdata, io_we, io_req,
    output mem_rdata, io_ack, io_rdata
  );

endinterface

// File: rtl/mem_io_unit_io_timeout_counter.sv
// Loadable up-counter timing an outstanding IO request.
// Ports: clock, reset (sync, low), load (clear), en (count), tc.
module io_timeout_counter #(
  parameter int LIMIT = 255,
  parameter int W     = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic tc
);

  logic [W-1:0] count;

  always_ff @(posedge clock) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (en) begin
      count <= count + W'(1);
    end
  end

  assign tc = (count == W'(LIMIT - 1));

endmodule

// File: rtl/mem_io_unit.sv
// Memory/IO access stage: sequences RAM and IO accesses, stalls core.
// Ports: clock, reset, MemRead/MemWrite/addr/wdata in; read_data/stall/misalign/io_err out; bus.
module mem_io_unit
  import mem_io_pkg::*;
#(
  parameter int          MEM_ADDR_W = MEM_ADDR_W_DEF,
  parameter logic [21:0] IO_BASE_HI = IO_BASE_HI_DEF,
  parameter int          IO_TIMEOUT = IO_TIMEOUT_DEF
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          MemRead,
  input  logic          MemWrite,
  input  logic [31:0]   addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   read_data,
  output logic          stall,
  output logic          misalign,
  output logic          io_err,
  mem_io_unit_if.master bus
);

  localparam int CNT_W = (IO_TIMEOUT > 1) ? $clog2(IO_TIMEOUT) : 1;

  state_t state;
  state_t state_nx;
  acc_t   acc;
  logic   active;
  logic   unaligned;
  logic   mem_we;
  logic   cnt_load;
  logic   cnt_en;
  logic   tc;

  assign active    = MemRead | MemWrite;
  assign unaligned = (addr[1:0] != 2'b00);
  // Misaligned accesses are dropped entirely.
  assign acc = unaligned ? ACC_NONE
             : decode_acc(MemRead, MemWrite, addr, IO_BASE_HI);

  assign bus.mem_addr  = addr[MEM_ADDR_W+1:2];
  assign bus.mem_wdata = wdata;
  assign bus.mem_we    = mem_we;

  io_timeout_counter #(
    .LIMIT (IO_TIMEOUT),
    .W     (CNT_W)
  ) u_tmo (
    .clock (clock),
    .reset (reset),
    .load  (cnt_load),
    .en    (cnt_en),
    .tc    (tc)
  );

  always_comb begin
    state_nx = state;
    stall    = 1'b0;
    mem_we   = 1'b0;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        unique case (acc)
          ACC_MEM_WR: mem_we = 1'b1;
          ACC_MEM_RD: begin
            stall    = 1'b1;
            state_nx = ST_MEM_RD;
          end
          ACC_IO_RD, ACC_IO_WR: begin
            stall    = 1'b1;
            cnt_load = 1'b1;
            state_nx = ST_IO_WAIT;
          end
          default: ;
        endcase
      end
      ST_MEM_RD: begin
        stall    = 1'b1;
        state_nx = ST_DONE;
      end
      ST_IO_WAIT: begin
        stall = 1'b1;
        if (bus.io_ack || tc) begin
          state_nx = ST_DONE;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state        <= ST_IDLE;
      read_data    <= '0;
      bus.io_req   <= 1'b0;
      bus.io_we    <= 1'b0;
      bus.io_addr  <= '0;
      bus.io_wdata <= '0;
      io_err       <= 1'b0;
      misalign     <= 1'b0;
    end else begin
      state    <= state_nx;
      misalign <= (state == ST_IDLE) && active && unaligned;
      unique case (state)
        ST_IDLE: begin
          if (acc == ACC_IO_RD || acc == ACC_IO_WR) begin
            bus.io_req   <= 1'b1;
            bus.io_addr  <= addr[9:0];
            bus.io_wdata <= wdata;
            bus.io_we    <= (acc == ACC_IO_WR);
          end
        end
        ST_MEM_RD: read_data <= bus.mem_rdata;
        ST_IO_WAIT: begin
          // Ack on the terminal cycle still completes cleanly.
          if (bus.io_ack) begin
            bus.io_req <= 1'b0;
            if (!bus.io_we) read_data <= bus.io_rdata;
          end else if (tc) begin
            bus.io_req <= 1'b0;
            io_err     <= 1'b1;
            if (!bus.io_we) read_data <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_io_unit.sv
// Directed bench for mem_io_unit with RAM model and load scoreboard.
// Covers store/load, IO ack, IO timeout, misalign, reset mid-IO.
module tb_mem_io_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] read_data;
  logic        stall;
  logic        misalign;
  logic        io_err;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] ram [0:16383];

  always #5 clock = ~clock;

  mem_io_unit_if #(.MEM_ADDR_W(14)) bus();

  mem_io_unit #(
    .MEM_ADDR_W (14),
    .IO_BASE_HI (22'h3FFFFF),
    .IO_TIMEOUT (8)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .addr      (addr),
    .wdata     (wdata),
    .read_data (read_data),
    .stall     (stall),
    .misalign  (misalign),
    .io_err    (io_err),
    .bus       (bus)
  );

  always @(posedge clock) begin
    if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic idle_in;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    addr     = '0;
    wdata    = '0;
  endtask

  // Entered at posedge+1; returns at posedge+2 of the first unstalled cycle.
  task automatic run_access(
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] a,
    input  logic [31:0] d,
    input  int          ack_at,
    input  logic [31:0] ack_data,
    output int          st_cyc,
    output int          rq_cyc,
    output logic [31:0] cap_addr,
    output logic        cap_we,
    output logic [31:0] cap_wdata
  );
    bit fin;
    fin       = 1'b0;
    MemRead   = rd;
    MemWrite  = wr;
    addr      = a;
    wdata     = d;
    st_cyc    = 0;
    rq_cyc    = 0;
    cap_addr  = '0;
    cap_we    = 1'b0;
    cap_wdata = '0;
    for (int k = 0; k < 400 && !fin; k++) begin
      #1;
      if (bus.io_req) begin
        rq_cyc++;
        if (rq_cyc == 1) begin
          cap_addr  = {22'h0, bus.io_addr};
          cap_we    = bus.io_we;
          cap_wdata = bus.io_wdata;
        end
        bus.io_ack   = (rq_cyc == ack_at);
        bus.io_rdata = ack_data;
      end
      if (!stall) fin = 1'b1;
      else st_cyc++;
      if (!fin) begin
        tick;
        bus.io_ack = 1'b0;
      end
    end
    if (!fin) begin
      total++;
      bad++;
      $error("FAIL access_bound got=stalled exp=done addr=%h", a);
    end
  endtask

  int          st;
  int          rq;
  logic [31:0] ca;
  logic        cw;
  logic [31:0] cd;

  initial begin
    reset        = 1'b0;
    idle_in();
    bus.io_ack   = 1'b0;
    bus.io_rdata = '0;
    tick;
    tick;
    #1;
    chk("rst_read_data", read_data, 32'h0);
    chk("rst_stall", {31'h0, stall}, 32'h0);
    chk("rst_io_req", {31'h0, bus.io_req}, 32'h0);
    chk("rst_io_we", {31'h0, bus.io_we}, 32'h0);
    chk("rst_io_addr", {22'h0, bus.io_addr}, 32'h0);
    chk("rst_io_wdata", bus.io_wdata, 32'h0);
    chk("rst_io_err", {31'h0, io_err}, 32'h0);
    chk("rst_misalign", {31'h0, misalign}, 32'h0);
    reset = 1'b1;
    tick;

    MemWrite = 1'b1;
    addr     = 32'h0000_0010;
    wdata    = 32'hCAFE_F00D;
    #1;
    chk("st_mem_we", {31'h0, bus.mem_we}, 32'h1);
    chk("st_mem_addr", {18'h0, bus.mem_addr}, 32'h4);
    chk("st_mem_wdata", bus.mem_wdata, 32'hCAFE_F00D);
    chk("st_stall", {31'h0, stall}, 32'h0);
    tick;
    idle_in();

    exp_q.push_back(32'hCAFE_F00D);
    run_access(1'b1, 1'b0, 32'h10, 32'h0, 0, 32'h0, st, rq, ca, cw, cd);
    chk("ld_stall_cyc", st, 32'd2);
    chk("ld_data", read_data, exp_q.pop_front());
    chk("ld_no_io", rq, 32'd0);
    tick;
    idle_in();

    exp_q.push_back(32'h0000_ABCD);
    run_access(1'b1, 1'b0, 32'hFFFF_FC70, 32'h0, 5, 32'h0000_ABCD,
               st, rq, ca, cw, cd);
    chk("iord_req_cyc", rq, 32'd5);
    chk("iord_stall_cyc", st, 32'd6);
    chk("iord_addr", ca, 32'h070);
    chk("iord_we", {31'h0, cw}, 32'h0);
    chk("iord_data", read_data, exp_q.pop_front());
    chk("iord_err", {31'h0, io_err}, 32'h0);
    tick;
    idle_in();

    run_access(1'b0, 1'b1, 32'hFFFF_FC04, 32'h1234_5678, 0, 32'h0,
               st, rq, ca, cw, cd);
    chk("tmo_req_cyc", rq, 32'd8);
    chk("tmo_stall_cyc", st, 32'd9);
    chk("tmo_err", {31'h0, io_err}, 32'h1);
    chk("tmo_we", {31'h0, cw}, 32'h1);
    chk("tmo_wdata", cd, 32'h1234_5678);
    chk("tmo_addr", ca, 32'h004);
    chk("tmo_rd_keep", read_data, 32'h0000_ABCD);
    chk("tmo_req_drop", {31'h0, bus.io_req}, 32'h0);
    tick;
    idle_in();

    MemRead = 1'b1;
    addr    = 32'h0000_0006;
    #1;
    chk("mis_stall", {31'h0, stall}, 32'h0);
    chk("mis_mem_we", {31'h0, bus.mem_we}, 32'h0);
    chk("mis_pre", {31'h0, misalign}, 32'h0);
    tick;
    idle_in();
    #1;
    chk("mis_pulse", {31'h0, misalign}, 32'h1);
    chk("mis_io_req", {31'h0, bus.io_req}, 32'h0);
    chk("mis_rd_keep", read_data, 32'h0000_ABCD);
    tick;
    #1;
    chk("mis_end", {31'h0, misalign}, 32'h0);
    tick;

    MemRead  = 1'b1;
    MemWrite = 1'b1;
    addr     = 32'h0000_0020;
    wdata    = 32'h55AA_55AA;
    #1;
    chk("both_mem_we", {31'h0, bus.mem_we}, 32'h1);
    chk("both_stall", {31'h0, stall}, 32'h0);
    chk("both_addr", {18'h0, bus.mem_addr}, 32'h8);
    tick;
    idle_in();

    exp_q.push_back(32'h55AA_55AA);
    run_access(1'b1, 1'b0, 32'h20, 32'h0, 0, 32'h0, st, rq, ca, cw, cd);
    chk("ld2_data", read_data, exp_q.pop_front());
    chk("ld2_stall_cyc", st, 32'd2);
    chk("err_sticky_ram", {31'h0, io_err}, 32'h1);
    tick;
    idle_in();

    exp_q.push_back(32'h0000_0077);
    run_access(1'b1, 1'b0, 32'hFFFF_FC80, 32'h0, 2, 32'h0000_0077,
               st, rq, ca, cw, cd);
    chk("iord2_data", read_data, exp_q.pop_front());
    chk("iord2_req_cyc", rq, 32'd2);
    chk("err_sticky_io", {31'h0, io_err}, 32'h1);
    tick;
    idle_in();

    MemRead = 1'b1;
    addr    = 32'hFFFF_FC10;
    tick;
    #1;
    chk("rmid_req", {31'h0, bus.io_req}, 32'h1);
    chk("rmid_stall", {31'h0, stall}, 32'h1);
    reset = 1'b0;
    idle_in();
    tick;
    #1;
    chk("rmid_req_drop", {31'h0, bus.io_req}, 32'h0);
    chk("rmid_stall0", {31'h0, stall}, 32'h0);
    chk("rmid_rd0", read_data, 32'h0);
    chk("rmid_err0", {31'h0, io_err}, 32'h0);
    reset        = 1'b1;
    bus.io_ack   = 1'b1;
    bus.io_rdata = 32'hDEAD_BEEF;
    tick;
    bus.io_ack = 1'b0;
    #1;
    chk("late_ack_rd", read_data, 32'h0);
    chk("late_ack_req", {31'h0, bus.io_req}, 32'h0);
    chk("late_ack_stall", {31'h0, stall}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
